// File: rtl/ttl_updn_counter_sync.sv
// Parametrised synchronous up/down counter (74160/161/169 family) with load, ENT/ENP, direction and RCO.
// Build option: define TTL_CNT_CEN_EDGE_EN to advance on Cen rising edges instead of Cen level.
module ttl_updn_counter_sync #(
    parameter int unsigned      WIDTH   = 4,
    parameter longint unsigned  MODULUS = 16
) (
    input  logic             Clk,
    input  logic             Clear_bar,
    input  logic             Cen,
    input  logic             Load_bar,
    input  logic             ENT,
    input  logic             ENP,
    input  logic             U_D,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             RCO
);

    // MODULUS may be 2**32 for a 32-bit counter, hence the 64-bit parameter and explicit truncation.
    localparam logic [WIDTH-1:0] TC_UP = WIDTH'(MODULUS - 64'd1);
    localparam logic [WIDTH-1:0] TC_DN = '0;
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    logic             adv;
    logic [WIDTH-1:0] q_next;

`ifdef TTL_CNT_CEN_EDGE_EN
    // last_cen resets high so a Cen held high through reset release does not step.
    logic last_cen;

    always_ff @(posedge Clk) begin
        if (!Clear_bar) begin
            last_cen <= 1'b1;
        end else begin
            last_cen <= Cen;
        end
    end

    assign adv = Cen & ~last_cen;
`else
    assign adv = Cen;
`endif

    // Load beats count; out-of-range values wrap to 0 on the next up step.
    always_comb begin
        q_next = Q;
        if (adv) begin
            if (!Load_bar) begin
                q_next = D;
            end else if (ENT && ENP) begin
                if (U_D) begin
                    q_next = (Q >= TC_UP) ? '0 : Q + ONE;
                end else begin
                    q_next = (Q == TC_DN) ? TC_UP : Q - ONE;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Clear_bar) begin
            Q <= '0;
        end else begin
            Q <= q_next;
        end
    end

    assign RCO = ENT & (U_D ? (Q == TC_UP) : (Q == TC_DN));

endmodule

// File: tb/tb_ttl_updn_counter_sync.sv
// Self-checking bench for ttl_updn_counter_sync (WIDTH=4, MODULUS=10), both Cen build modes.
module tb_ttl_updn_counter_sync;

    logic       Clk;
    logic       Clear_bar;
    logic       Cen;
    logic       Load_bar;
    logic       ENT;
    logic       ENP;
    logic       U_D;
    logic [3:0] D;
    logic [3:0] Q;
    logic       RCO;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       clr_n;
        logic       cen;
        logic       load_n;
        logic       ent;
        logic       enp;
        logic       ud;
        logic [3:0] d;
        logic [3:0] exp_q;
        logic       exp_rco;
        string      name;
    } vec_t;

    typedef struct {
        logic [3:0] q;
        logic       rco;
        string      name;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    ttl_updn_counter_sync #(.WIDTH(4), .MODULUS(10)) dut (
        .Clk       (Clk),
        .Clear_bar (Clear_bar),
        .Cen       (Cen),
        .Load_bar  (Load_bar),
        .ENT       (ENT),
        .ENP       (ENP),
        .U_D       (U_D),
        .D         (D),
        .Q         (Q),
        .RCO       (RCO)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic vec_t mk(input logic clr_n, input logic cen, input logic load_n,
                                input logic ent, input logic enp, input logic ud,
                                input logic [3:0] d, input logic [3:0] exp_q,
                                input logic exp_rco, input string name);
        vec_t v;
        v.clr_n = clr_n; v.cen = cen; v.load_n = load_n; v.ent = ent; v.enp = enp;
        v.ud = ud; v.d = d; v.exp_q = exp_q; v.exp_rco = exp_rco; v.name = name;
        return v;
    endfunction

    task automatic check_one();
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty: no expected entry at time %0t", $time);
        end else begin
            e = sb.pop_front();
            n_checks++;
            if (Q !== e.q) begin
                n_fail++;
                $display("FAIL %s Q: got %0d expected %0d", e.name, Q, e.q);
            end
            n_checks++;
            if (RCO !== e.rco) begin
                n_fail++;
                $display("FAIL %s RCO: got %0b expected %0b", e.name, RCO, e.rco);
            end
        end
    endtask

    // Drive one cycle on the falling edge, check 1 time unit after the next rising edge.
    task automatic cycle(input vec_t v);
        exp_t e;
        @(negedge Clk);
        Clear_bar = v.clr_n; Cen = v.cen; Load_bar = v.load_n;
        ENT = v.ent; ENP = v.enp; U_D = v.ud; D = v.d;
        e.q = v.exp_q; e.rco = v.exp_rco; e.name = v.name;
        sb.push_back(e);
        @(posedge Clk);
        #1;
        check_one();
    endtask

    // Table row followed by an idle Cen=0 cycle so pulses are one Clk wide in both builds.
    task automatic apply(input vec_t v);
        vec_t idle;
        cycle(v);
        idle = v;
        idle.clr_n = 1'b1;
        idle.cen   = 1'b0;
        idle.name  = {v.name, "_idle"};
        cycle(idle);
    endtask

    initial begin
        vec_t v;
        Clear_bar = 1'b1; Cen = 1'b0; Load_bar = 1'b1;
        ENT = 1'b0; ENP = 1'b0; U_D = 1'b1; D = 4'd0;

        // clr cen ld_n ent enp ud d  q rco
        vecs.push_back(mk(0, 1, 0, 1, 1, 1, 4'd7, 4'd0, 0, "reset_beats_load"));
        for (int i = 1; i <= 12; i++) begin
            logic [3:0] q;
            q = 4'(i % 10);
            vecs.push_back(mk(1, 1, 1, 1, 1, 1, 4'd0, q, q == 4'd9, "bcd_up"));
        end
        vecs.push_back(mk(1, 1, 0, 1, 1, 0, 4'd1, 4'd1, 0, "load_1_down"));
        vecs.push_back(mk(1, 1, 1, 1, 1, 0, 4'd0, 4'd0, 1, "down_to_0_borrow"));
        vecs.push_back(mk(1, 0, 1, 0, 1, 0, 4'd0, 4'd0, 0, "rco_gated_by_ent"));
        vecs.push_back(mk(1, 0, 1, 1, 1, 1, 4'd0, 4'd0, 0, "rco_follows_ud"));
        vecs.push_back(mk(1, 1, 1, 1, 1, 0, 4'd0, 4'd9, 0, "down_wrap_9"));
        vecs.push_back(mk(1, 1, 1, 1, 1, 0, 4'd0, 4'd8, 0, "down_8"));
        vecs.push_back(mk(1, 1, 1, 1, 0, 1, 4'd0, 4'd8, 0, "enp_low_hold"));
        vecs.push_back(mk(1, 1, 1, 0, 1, 1, 4'd0, 4'd8, 0, "ent_low_hold"));
        vecs.push_back(mk(1, 1, 0, 0, 0, 1, 4'd5, 4'd5, 0, "load_ignores_en"));
        vecs.push_back(mk(1, 1, 0, 1, 1, 1, 4'd12, 4'd12, 0, "oor_load_up"));
        vecs.push_back(mk(1, 1, 1, 1, 1, 1, 4'd0, 4'd0, 0, "oor_up_wraps_0"));
        vecs.push_back(mk(1, 1, 0, 1, 1, 0, 4'd12, 4'd12, 0, "oor_load_down"));
        vecs.push_back(mk(1, 1, 1, 1, 1, 0, 4'd0, 4'd11, 0, "oor_down_11"));
        vecs.push_back(mk(1, 1, 0, 1, 1, 1, 4'd9, 4'd9, 1, "load_9_rco"));
        vecs.push_back(mk(0, 0, 1, 1, 1, 1, 4'd0, 4'd0, 0, "reset_without_cen"));

        foreach (vecs[i]) apply(vecs[i]);

        // Cen held high for 5 Clk from Q=0.
        for (int i = 1; i <= 5; i++) begin
`ifdef TTL_CNT_CEN_EDGE_EN
            v = mk(1, 1, 1, 1, 1, 1, 4'd0, 4'd1, 0, "cen_high_one_step");
`else
            v = mk(1, 1, 1, 1, 1, 1, 4'd0, 4'(i), 0, "cen_high_level_steps");
`endif
            cycle(v);
        end

        // Cen held high across reset release.
        cycle(mk(0, 1, 1, 1, 1, 1, 4'd0, 4'd0, 0, "reset_cen_high"));
        for (int i = 1; i <= 3; i++) begin
`ifdef TTL_CNT_CEN_EDGE_EN
            v = mk(1, 1, 1, 1, 1, 1, 4'd0, 4'd0, 0, "no_step_after_reset");
`else
            v = mk(1, 1, 1, 1, 1, 1, 4'd0, 4'(i), 0, "level_step_after_reset");
`endif
            cycle(v);
        end
`ifdef TTL_CNT_CEN_EDGE_EN
        cycle(mk(1, 0, 1, 1, 1, 1, 4'd0, 4'd0, 0, "cen_low"));
        cycle(mk(1, 1, 1, 1, 1, 1, 4'd0, 4'd1, 0, "cen_rise_steps"));
`else
        cycle(mk(1, 0, 1, 1, 1, 1, 4'd0, 4'd3, 0, "cen_low"));
        cycle(mk(1, 1, 1, 1, 1, 1, 4'd0, 4'd4, 0, "cen_rise_steps"));
`endif

        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
